ex_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register of the 5-stage pipelined CPU. It consumes the ID/EX register outputs and resolves operand forwarding from EX/MEM and MEM/WB. It computes the ALU result, including an iterative 32-cycle multiplier that stalls the front end, and registers everything the MEM stage needs.

---
 rtl/ex_pkg.sv | 74 +++++++
 rtl/ex_mul_if.sv | 26 ++
 rtl/ex_mul_iter.sv | 71 +++++++
 rtl/ex_stage.sv | 172 +++++++++++++++++
 tb/tb_ex_stage.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the execute stage.
//   - ALUOp encodings driven by the decode stage
//   - funct3 / funct7 field values used by the ALU decoder
//   - ALU-control enum and the decoder function that produces it
//   - iterative multiplier state enum
package ex_pkg;

  localparam logic [2:0] ALUOP_LS = 3'b000;  // load/store address add
  localparam logic [2:0] ALUOP_R  = 3'b010;  // register-register
  localparam logic [2:0] ALUOP_I  = 3'b011;  // register-immediate

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRA,
    ALU_MUL
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  // Any combination not listed decodes to ALU_NONE, which yields result 0.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] alu_op,
                                           input logic [6:0] funct7,
                                           input logic [2:0] funct3);
    alu_ctrl_e ctrl;
    ctrl = ALU_NONE;
    case (alu_op)
      ALUOP_LS: ctrl = ALU_ADD;
      ALUOP_R: begin
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: ctrl = ALU_ADD;
          {F7_ALT,  F3_ADD}: ctrl = ALU_SUB;
          {F7_BASE, F3_AND}: ctrl = ALU_AND;
          {F7_BASE, F3_OR }: ctrl = ALU_OR;
          {F7_BASE, F3_XOR}: ctrl = ALU_XOR;
          {F7_BASE, F3_SLL}: ctrl = ALU_SLL;
          {F7_ALT,  F3_SRA}: ctrl = ALU_SRA;
          {F7_MUL,  F3_ADD}: ctrl = ALU_MUL;
          default:           ctrl = ALU_NONE;
        endcase
      end
      ALUOP_I: begin
        case (funct3)
          F3_ADD:  ctrl = ALU_ADD;
          F3_SRA:  ctrl = ALU_SRA;
          default: ctrl = ALU_NONE;
        endcase
      end
      default: ctrl = ALU_NONE;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_mul_if.sv
// ex_mul_if: connection between the execute stage and the iterative
// multiplier.
//   start   : master -> slave, level request; accepted only while the unit
//             is IDLE, operands op_a/op_b are sampled on that edge
//   op_a/b  : master -> slave, 32-bit operands
//   busy    : slave -> master, unit is iterating (state BUSY)
//   done    : slave -> master, one-cycle pulse; product is valid while high
//   product : slave -> master, low 32 bits of op_a * op_b
//   state   : slave -> master, FSM state for observation
// Handshake: a request is taken when start=1 and state=IDLE; the result is
// delivered when done=1. There is no back-pressure on done: the master must
// consume the product in that cycle.
interface ex_mul_if import ex_pkg::*; ();
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  mul_state_e  state;

  modport master (output start, op_a, op_b,
                  input  busy, done, product, state);
  modport slave  (input  start, op_a, op_b,
                  output busy, done, product, state);
endinterface

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: 32-cycle shift-add multiplier, low 32 bits of the product.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-low reset (aborts any operation)
//   mul    : ex_mul_if slave (start/operands in, busy/done/product out)
// IDLE -> (start) latch operands -> BUSY for 32 steps -> DONE one cycle
// -> IDLE. DONE never restarts, so a still-held request is not re-run.
module ex_mul_iter import ex_pkg::*; (
  input  logic clk_i,
  input  logic rst_i,
  ex_mul_if.slave mul
);

  mul_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (mul.start) begin
          a_d     = mul.op_a;
          b_d     = mul.op_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Multiplicand shifts left, multiplier shifts right; bits shifted
        // past bit 31 only affect the discarded upper product half.
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mul.busy    = (state_q == BUSY);
  assign mul.done    = (state_q == DONE);
  assign mul.product = acc_q;
  assign mul.state   = state_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage plus EX/MEM pipeline register.
// Optional feature macro: EX_MUL_EN (iterative multiplier present).
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   ALUOp_i, ALUSrc_i      : ALU operation class, operand-B select
//   RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i : control passed to EX/MEM
//   RS1data_i, RS2data_i, Imm_i, Op_i : operands, immediate, instruction word
//   EXMEM_RegWrite_i, EXMEM_RD_i : forwarding source 1 (value = ALUResult_o)
//   MEMWB_RegWrite_i, MEMWB_RD_i, MEMWB_data_i : forwarding source 2
//   ALUResult_o, MemData_o, RD_o, RegWrite_o, MemtoReg_o, MemRead_o,
//   MemWrite_o             : registered EX/MEM contents
//   Stall_o                : combinational front-end hold during a multiply
module ex_stage import ex_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  ALUOp_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] Imm_i,
  input  logic [31:0] Op_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_RD_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RD_i,
  input  logic [31:0] MEMWB_data_i,
  output logic [31:0] ALUResult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RD_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Stall_o
);

  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_opcode;

  assign rs1    = Op_i[19:15];
  assign rs2    = Op_i[24:20];
  assign rd     = Op_i[11:7];
  assign funct3 = Op_i[14:12];
  assign funct7 = Op_i[31:25];
  assign unused_opcode = ^Op_i[6:0];

  logic [31:0] result_q, result_d;
  logic [31:0] memdata_q, memdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic        mr_q, mr_d;
  logic        mw_q, mw_d;

  // Forwarding: EX/MEM beats MEM/WB; x0 is never forwarded.
  logic [31:0] fwd_a, fwd_b;
  always_comb begin
    fwd_a = RS1data_i;
    if (EXMEM_RegWrite_i && EXMEM_RD_i != 5'd0 && EXMEM_RD_i == rs1)
      fwd_a = result_q;
    else if (MEMWB_RegWrite_i && MEMWB_RD_i != 5'd0 && MEMWB_RD_i == rs1)
      fwd_a = MEMWB_data_i;

    fwd_b = RS2data_i;
    if (EXMEM_RegWrite_i && EXMEM_RD_i != 5'd0 && EXMEM_RD_i == rs2)
      fwd_b = result_q;
    else if (MEMWB_RegWrite_i && MEMWB_RD_i != 5'd0 && MEMWB_RD_i == rs2)
      fwd_b = MEMWB_data_i;
  end

  alu_ctrl_e   alu_ctrl;
  logic [31:0] op_b;
  logic [31:0] mul_result;
  logic [31:0] alu_res;

  assign alu_ctrl = alu_decode(ALUOp_i, funct7, funct3);
  assign op_b     = ALUSrc_i ? Imm_i : fwd_b;

`ifdef EX_MUL_EN
  logic is_mul;
  ex_mul_if mul_bus ();

  assign is_mul        = (alu_ctrl == ALU_MUL);
  assign mul_bus.start = is_mul;
  assign mul_bus.op_a  = fwd_a;
  assign mul_bus.op_b  = op_b;

  ex_mul_iter u_mul (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mul   (mul_bus)
  );

  // Held low in reset so the front end is free while the FSM is cleared.
  assign Stall_o    = rst_i & ((is_mul & (mul_bus.state == IDLE)) | mul_bus.busy);
  assign mul_result = mul_bus.product;
`else
  assign Stall_o    = 1'b0;
  assign mul_result = 32'd0;
`endif

  always_comb begin
    alu_res = 32'd0;
    case (alu_ctrl)
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_XOR: alu_res = fwd_a ^ op_b;
      ALU_SLL: alu_res = fwd_a << op_b[4:0];
      ALU_SRA: alu_res = $unsigned($signed(fwd_a) >>> op_b[4:0]);
      // Only reached un-stalled in DONE, when the product is final.
      ALU_MUL: alu_res = mul_result;
      default: alu_res = 32'd0;
    endcase
  end

  // EX/MEM next state: a bubble whenever the front end is held.
  always_comb begin
    result_d  = alu_res;
    memdata_d = fwd_b;
    rd_d      = rd;
    rw_d      = RegWrite_i;
    m2r_d     = MemtoReg_i;
    mr_d      = MemRead_i;
    mw_d      = MemWrite_i;
    if (Stall_o) begin
      result_d  = 32'd0;
      memdata_d = 32'd0;
      rd_d      = 5'd0;
      rw_d      = 1'b0;
      m2r_d     = 1'b0;
      mr_d      = 1'b0;
      mw_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q  <= '0;
      memdata_q <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
    end else begin
      result_q  <= result_d;
      memdata_q <= memdata_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      mr_q      <= mr_d;
      mw_q      <= mw_d;
    end
  end

  assign ALUResult_o = result_q;
  assign MemData_o   = memdata_q;
  assign RD_o        = rd_q;
  assign RegWrite_o  = rw_q;
  assign MemtoReg_o  = m2r_q;
  assign MemRead_o   = mr_q;
  assign MemWrite_o  = mw_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage and the standalone multiplier.
// Multiplier expectations follow EX_MUL_EN the same way the design does.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk_i, rst_i;
  logic [2:0]  ALUOp_i;
  logic        ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i, Op_i;
  logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic [4:0]  EXMEM_RD_i, MEMWB_RD_i;
  logic [31:0] MEMWB_data_i;
  logic [31:0] ALUResult_o, MemData_o;
  logic [4:0]  RD_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Stall_o;

  int errors = 0;
  int checks = 0;

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  ex_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ALUOp_i          (ALUOp_i),
    .ALUSrc_i         (ALUSrc_i),
    .RegWrite_i       (RegWrite_i),
    .MemtoReg_i       (MemtoReg_i),
    .MemRead_i        (MemRead_i),
    .MemWrite_i       (MemWrite_i),
    .RS1data_i        (RS1data_i),
    .RS2data_i        (RS2data_i),
    .Imm_i            (Imm_i),
    .Op_i             (Op_i),
    .EXMEM_RegWrite_i (EXMEM_RegWrite_i),
    .EXMEM_RD_i       (EXMEM_RD_i),
    .MEMWB_RegWrite_i (MEMWB_RegWrite_i),
    .MEMWB_RD_i       (MEMWB_RD_i),
    .MEMWB_data_i     (MEMWB_data_i),
    .ALUResult_o      (ALUResult_o),
    .MemData_o        (MemData_o),
    .RD_o             (RD_o),
    .RegWrite_o       (RegWrite_o),
    .MemtoReg_o       (MemtoReg_o),
    .MemRead_o        (MemRead_o),
    .MemWrite_o       (MemWrite_o),
    .Stall_o          (Stall_o)
  );

  ex_mul_if tb_mul_bus ();
  ex_mul_iter u_tb_mul (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mul   (tb_mul_bus)
  );

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic present(input logic [2:0] aluop, input logic alusrc, input logic rw,
                         input logic m2r, input logic mr, input logic mw,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] op);
    ALUOp_i = aluop; ALUSrc_i = alusrc; RegWrite_i = rw; MemtoReg_i = m2r;
    MemRead_i = mr; MemWrite_i = mw; RS1data_i = a; RS2data_i = b;
    Imm_i = imm; Op_i = op;
  endtask

  task automatic clear_fwd();
    EXMEM_RegWrite_i = 1'b0; EXMEM_RD_i = 5'd0;
    MEMWB_RegWrite_i = 1'b0; MEMWB_RD_i = 5'd0; MEMWB_data_i = 32'd0;
  endtask

  // Advance while stalled; every edge taken under stall must load a bubble.
  task automatic wait_mul(output int n, output int bad);
    n = 0;
    bad = 0;
    #1;
    while (Stall_o === 1'b1 && n < 40) begin
      step();
      n++;
      if (ALUResult_o !== 32'd0 || RegWrite_o !== 1'b0 || RD_o !== 5'd0 ||
          MemData_o !== 32'd0) bad++;
    end
  endtask

  int n, bad;

  initial begin
    rst_i = 1'b0;
    present(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    clear_fwd();
    tb_mul_bus.start = 1'b0; tb_mul_bus.op_a = 32'd0; tb_mul_bus.op_b = 32'd0;
    step(); step();

    // reset state
    chk("rst_result", ALUResult_o, 32'd0);
    chk("rst_memdata", MemData_o, 32'd0);
    chk("rst_rd", {27'd0, RD_o}, 32'd0);
    chk("rst_ctrl", {28'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, 32'd0);
    chk("rst_stall", {31'd0, Stall_o}, 32'd0);

    // add 5 + 7
    rst_i = 1'b1;
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd5));
    step();
    chk("add_result", ALUResult_o, 32'd12);
    chk("add_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("add_rd", {27'd0, RD_o}, 32'd5);

    // produce 100 into EX/MEM, then forward it into a sub
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd60, 32'd40, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3));
    step();
    chk("seed_100", ALUResult_o, 32'd100);
    EXMEM_RegWrite_i = 1'b1; EXMEM_RD_i = 5'd3;
    MEMWB_RegWrite_i = 1'b1; MEMWB_RD_i = 5'd3; MEMWB_data_i = 32'd50;
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd200, 32'd1, 32'd0,
            r_op(F7_ALT, 5'd4, 5'd3, F3_ADD, 5'd6));
    step();
    chk("sub_fwd_exmem", ALUResult_o, 32'd99);
    EXMEM_RD_i = 5'd0;
    step();
    chk("sub_fwd_memwb", ALUResult_o, 32'd49);
    MEMWB_RD_i = 5'd0;
    step();
    chk("sub_fwd_none", ALUResult_o, 32'd199);
    clear_fwd();

    // shifts and logic
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0,
            r_op(F7_ALT, 5'd2, 5'd1, F3_SRA, 5'd7));
    step();
    chk("sra_r", ALUResult_o, 32'hF800_0000);
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd31, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, F3_SLL, 5'd7));
    step();
    chk("sll_31", ALUResult_o, 32'h8000_0000);
    present(ALUOP_I, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'h0000_0404,
            r_op(F7_ALT, 5'd4, 5'd1, F3_SRA, 5'd7));
    step();
    chk("srai", ALUResult_o, 32'hF800_0000);
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, F3_XOR, 5'd7));
    step();
    chk("xor", ALUResult_o, 32'h0000_0FF0);
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd7));
    step();
    chk("and", ALUResult_o, 32'h0000_F000);
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd7));
    step();
    chk("or", ALUResult_o, 32'h0000_FFF0);
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd9, 32'd0,
            r_op(F7_BASE, 5'd2, 5'd1, 3'b010, 5'd7));
    step();
    chk("undef_zero", ALUResult_o, 32'd0);

    // lw then sw with store data forwarded from EX/MEM
    present(ALUOP_LS, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'hFFFF_FFFC,
            r_op(7'd0, 5'd0, 5'd1, 3'b010, 5'd7));
    step();
    chk("lw_addr", ALUResult_o, 32'h0000_00FC);
    chk("lw_memread", {30'd0, MemRead_o, MemtoReg_o}, 32'd3);
    EXMEM_RegWrite_i = 1'b1; EXMEM_RD_i = 5'd7;
    present(ALUOP_LS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'd8,
            r_op(7'd0, 5'd7, 5'd1, 3'b010, 5'd8));
    step();
    chk("sw_addr", ALUResult_o, 32'h0000_0208);
    chk("sw_memdata", MemData_o, 32'h0000_00FC);
    chk("sw_ctrl", {29'd0, RegWrite_o, MemRead_o, MemWrite_o}, 32'd1);
    clear_fwd();

`ifdef EX_MUL_EN
    // mul 0xFFFFFFFF * 3
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0,
            r_op(F7_MUL, 5'd2, 5'd1, F3_ADD, 5'd9));
    wait_mul(n, bad);
    chk("mul1_stall_cycles", n, 32'd33);
    chk("mul1_bubbles", bad, 32'd0);
    step();
    chk("mul1_product", ALUResult_o, 32'hFFFF_FFFD);
    chk("mul1_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("mul1_rd", {27'd0, RD_o}, 32'd9);

    // back-to-back mul; MEM/WB change during BUSY must not matter
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_0001, 32'h0001_0001, 32'd0,
            r_op(F7_MUL, 5'd2, 5'd1, F3_ADD, 5'd11));
    #1;
    chk("mul2_stall_start", {31'd0, Stall_o}, 32'd1);
    repeat (5) step();
    MEMWB_RegWrite_i = 1'b1; MEMWB_RD_i = 5'd1; MEMWB_data_i = 32'd7;
    wait_mul(n, bad);
    chk("mul2_spacing", n + 6, 32'd34);
    step();
    chk("mul2_product", ALUResult_o, 32'h0002_0001);
    chk("mul2_rd", {27'd0, RD_o}, 32'd11);
    clear_fwd();

    // reset pulse mid-multiply, then re-run
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0,
            r_op(F7_MUL, 5'd2, 5'd1, F3_ADD, 5'd10));
    repeat (11) step();
    chk("mulrst_busy_stall", {31'd0, Stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mulrst_stall", {31'd0, Stall_o}, 32'd0);
    chk("mulrst_result", ALUResult_o, 32'd0);
    chk("mulrst_ctrl", {27'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Stall_o}, 32'd0);
    step();
    rst_i = 1'b1;
    wait_mul(n, bad);
    chk("mulrst_rerun_cycles", n, 32'd33);
    step();
    chk("mulrst_rerun_product", ALUResult_o, 32'd42);
    chk("mulrst_rerun_rd", {27'd0, RD_o}, 32'd10);
`else
    // without the multiplier the mul encoding is a plain 1-cycle zero
    present(ALUOP_R, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'd0,
            r_op(F7_MUL, 5'd2, 5'd1, F3_ADD, 5'd9));
    #1;
    chk("nomul_stall", {31'd0, Stall_o}, 32'd0);
    step();
    chk("nomul_result", ALUResult_o, 32'd0);
    chk("nomul_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("nomul_rd", {27'd0, RD_o}, 32'd9);
`endif

    // standalone multiplier unit: 0xFFFFFFFF^2 low word = 1
    present(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    tb_mul_bus.start = 1'b1;
    tb_mul_bus.op_a  = 32'hFFFF_FFFF;
    tb_mul_bus.op_b  = 32'hFFFF_FFFF;
    step();
    tb_mul_bus.start = 1'b0;
    chk("unit_busy", {31'd0, tb_mul_bus.busy}, 32'd1);
    n = 0;
    while (tb_mul_bus.done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("unit_cycles", n, 32'd32);
    chk("unit_product", tb_mul_bus.product, 32'd1);
    step();
    chk("unit_idle", {30'd0, tb_mul_bus.state}, {30'd0, IDLE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
